// File: rtl/msk_pkg.sv
// ---------------------------------------------------------------------------
// msk_pkg
// Shared definitions for the masked XOR accumulator slice:
//   - msk_state_e : accumulator FSM encoding (IDLE / ACC / FULL)
//   - share_idx   : flat bit index of share s, channel j in a d-share sharing
//   - cnt_width   : width of an operand counter able to hold the value nops
//   - rnd_width   : width of the refresh randomness bus (at least one bit)
// ---------------------------------------------------------------------------
package msk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_FULL = 2'd2
    } msk_state_e;

    // Sharings are laid out share-major: share s of channel j sits at s*count+j.
    function automatic int share_idx(input int s, input int j, input int count);
        return s * count + j;
    endfunction

    function automatic int cnt_width(input int nops);
        return $clog2(nops + 1);
    endfunction

    // d-1 random shares per channel; a single dummy bit when d==1.
    function automatic int rnd_width(input int d, input int count);
        return (d > 1) ? count * (d - 1) : 1;
    endfunction

endpackage

// File: rtl/msk_xor_refresh.sv
// ---------------------------------------------------------------------------
// msk_xor_refresh
// Combinational sum-zero refresh of a d-share sharing of count channels.
// Shares 0..d-2 are XORed with their own rnd slice; share d-1 absorbs the
// XOR of all slices, so the unmasked value is preserved.
// Ports:
//   share_in  [count*d-1:0]          input sharing
//   rnd       [rnd_width(d,count)-1:0] fresh randomness, slice s at s*count
//   share_out [count*d-1:0]          refreshed sharing, same layout
// ---------------------------------------------------------------------------
module msk_xor_refresh
    import msk_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic [count*d-1:0]              share_in,
    input  logic [rnd_width(d, count)-1:0]  rnd,
    output logic [count*d-1:0]              share_out
);

    if (d == 1) begin : g_single
        // A single share cannot be refreshed; randomness is dropped.
        logic unused_rnd;
        assign unused_rnd = ^rnd;
        assign share_out  = share_in;
    end else begin : g_multi
        for (genvar j = 0; j < count; j++) begin : g_chan
            logic [d-2:0] col;
            for (genvar s = 0; s < d - 1; s++) begin : g_share
                assign col[s] = rnd[share_idx(s, j, count)];
                assign share_out[share_idx(s, j, count)] =
                    share_in[share_idx(s, j, count)] ^ col[s];
            end
            // Only place where randomness of different shares meets.
            assign share_out[share_idx(d - 1, j, count)] =
                share_in[share_idx(d - 1, j, count)] ^ (^col);
        end
    end

endmodule

// File: rtl/msk_xor_acc.sv
// ---------------------------------------------------------------------------
// msk_xor_acc
// Streaming masked XOR accumulator. Operands (d-share sharings of count bits)
// are XORed share-wise into a registered accumulator; on an operand flagged
// last, or once nops operands are absorbed, the (optionally refreshed) result
// is presented behind a valid/ready handshake.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      operand handshake
//   in_data [count*d-1:0]  operand sharing, share s of bit j at s*count+j
//   in_last                operand closes the accumulation
//   rnd                    refresh randomness, used when rnd_req=1
//   rnd_req                combinational: this cycle consumes rnd
//   out_valid/out_ready    result handshake
//   out_data [count*d-1:0] result sharing
//   out_nops               number of operands folded into out_data
// ---------------------------------------------------------------------------
module msk_xor_acc
    import msk_pkg::*;
#(
    parameter int d       = 2,
    parameter int count   = 1,
    parameter int nops    = 4,
    parameter int refresh = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [count*d-1:0]              in_data,
    input  logic                            in_last,
    input  logic [rnd_width(d, count)-1:0]  rnd,
    output logic                            rnd_req,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [count*d-1:0]              out_data,
    output logic [cnt_width(nops)-1:0]      out_nops
);

    localparam int DW = count * d;
    localparam int CW = cnt_width(nops);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ACC  = ST_ACC;
    localparam logic [1:0] FULL = ST_FULL;

    logic [1:0]    state;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [DW-1:0] res_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          accept;
    logic          fire;
    logic          close;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;

    // Only ACC folds into the held partial; IDLE and FULL (which can only
    // accept alongside a fire) start a fresh accumulation.
    assign acc_next = (state == ACC) ? (acc ^ in_data) : in_data;
    assign cnt_next = (state == ACC) ? (cnt + 1'b1) : CW'(1);
    assign close    = accept & (in_last | (cnt_next == CW'(nops)));

    if (refresh != 0) begin : g_refresh
        msk_xor_refresh #(
            .d     (d),
            .count (count)
        ) u_refresh (
            .share_in  (acc_next),
            .rnd       (rnd),
            .share_out (res_next)
        );
        assign rnd_req = (d > 1) ? close : 1'b0;
    end else begin : g_plain
        logic unused_rnd;
        assign unused_rnd = ^rnd;
        assign res_next   = acc_next;
        assign rnd_req    = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_nops  <= '0;
        end else begin
            if (accept) begin
                acc   <= acc_next;
                cnt   <= cnt_next;
                state <= close ? FULL : ACC;
            end else if (fire) begin
                state <= IDLE;
            end

            // A closing accept reloads the output even while the previous
            // result fires, so out_valid stays high back-to-back.
            if (close) begin
                out_valid <= 1'b1;
                out_data  <= res_next;
                out_nops  <= cnt_next;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msk_xor_acc.sv
module tb_msk_xor_acc;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  nops;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // DUT A: d=2, count=4, nops=4, no refresh
    logic       a_in_valid, a_in_ready, a_in_last, a_rnd_req, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [3:0] a_rnd;
    logic [2:0] a_out_nops;

    // DUT B: d=2, count=4, nops=2, no refresh
    logic       b_in_valid, b_in_ready, b_in_last, b_rnd_req, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [3:0] b_rnd;
    logic [1:0] b_out_nops;

    // DUT C: d=3, count=4, nops=4, refresh
    logic        c_in_valid, c_in_ready, c_in_last, c_rnd_req, c_out_valid, c_out_ready;
    logic [11:0] c_in_data, c_out_data;
    logic [7:0]  c_rnd;
    logic [2:0]  c_out_nops;

    msk_xor_acc #(.d(2), .count(4), .nops(4), .refresh(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .rnd(a_rnd), .rnd_req(a_rnd_req),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_nops(a_out_nops)
    );

    msk_xor_acc #(.d(2), .count(4), .nops(2), .refresh(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .rnd(b_rnd), .rnd_req(b_rnd_req),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_nops(b_out_nops)
    );

    msk_xor_acc #(.d(3), .count(4), .nops(4), .refresh(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .rnd(c_rnd), .rnd_req(c_rnd_req),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_nops(c_out_nops)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired / unexpected event", nm);
    endtask

    task automatic send_a(input logic [7:0] dat, input logic last);
        int n = 0;
        a_in_valid = 1'b1; a_in_data = dat; a_in_last = last;
        #1;
        while (!a_in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) fail_now("a_accept_timeout");
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] dat, input logic last);
        int n = 0;
        b_in_valid = 1'b1; b_in_data = dat; b_in_last = last;
        #1;
        while (!b_in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) fail_now("b_accept_timeout");
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    // Monitors: pop the expected result whenever a DUT output fires.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) fail_now("a_unexpected_output");
            else begin
                e = qa.pop_front();
                chk("a_out_data", {24'd0, a_out_data}, {20'd0, e.data});
                chk("a_out_nops", {29'd0, a_out_nops}, {29'd0, e.nops});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) fail_now("b_unexpected_output");
            else begin
                e = qb.pop_front();
                chk("b_out_data", {24'd0, b_out_data}, {20'd0, e.data});
                chk("b_out_nops", {30'd0, b_out_nops}, {29'd0, e.nops});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) fail_now("c_unexpected_output");
            else begin
                e = qc.pop_front();
                chk("c_out_data", {20'd0, c_out_data}, {20'd0, e.data});
                chk("c_out_nops", {29'd0, c_out_nops}, {29'd0, e.nops});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_rnd = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_rnd = 0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = 0; c_in_last = 0; c_rnd = 0; c_out_ready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 0);
        chk("rst_out_data",  {24'd0, a_out_data}, 0);
        chk("rst_out_nops",  {29'd0, a_out_nops}, 0);
        chk("rst_in_ready",  {31'd0, a_in_ready}, 1);
        chk("rst_rnd_req",   {31'd0, c_rnd_req}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three-operand accumulation: (3,5)^(A,0)^(1,1) = (8,4)
        qa.push_back('{data: 12'h048, nops: 3'd3});
        send_a(8'h53, 1'b0);
        send_a(8'h0A, 1'b0);
        chk("a_no_early_valid", {31'd0, a_out_valid}, 0);
        a_in_valid = 1'b1; a_in_data = 8'h11; a_in_last = 1'b1;
        #1;
        chk("a_rnd_req_plain", {31'd0, a_rnd_req}, 0);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
        chk("a_latency_valid", {31'd0, a_out_valid}, 1);
        @(posedge clk); #1;

        // Auto close at nops=2: 12^34=26, A5^0F=AA
        qb.push_back('{data: 12'h026, nops: 3'd2});
        qb.push_back('{data: 12'h0AA, nops: 3'd2});
        send_b(8'h12, 1'b0);
        send_b(8'h34, 1'b0);
        send_b(8'hA5, 1'b0);
        send_b(8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure then back-to-back fire/reload
        a_out_ready = 1'b0;
        qa.push_back('{data: 12'h077, nops: 3'd1});
        send_a(8'h77, 1'b1);
        a_in_valid = 1'b1; a_in_data = 8'h3C; a_in_last = 1'b1;
        qa.push_back('{data: 12'h03C, nops: 3'd1});
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready",  {31'd0, a_in_ready}, 0);
            chk("bp_out_valid", {31'd0, a_out_valid}, 1);
            chk("bp_out_data",  {24'd0, a_out_data}, 32'h77);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {31'd0, a_in_ready}, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
        chk("b2b_out_valid", {31'd0, a_out_valid}, 1);
        chk("b2b_out_data",  {24'd0, a_out_data}, 32'h3C);
        @(posedge clk); #1;

        // Refresh, two operands: 421^000 with rnd (F,9) -> (E,B,2)
        c_in_valid = 1'b1; c_in_data = 12'h421; c_in_last = 1'b0; c_rnd = 8'h00;
        #1;
        chk("c_rnd_req_open", {31'd0, c_rnd_req}, 0);
        @(posedge clk); #1;
        qc.push_back('{data: 12'h2BE, nops: 3'd2});
        c_in_data = 12'h000; c_in_last = 1'b1; c_rnd = 8'h9F;
        #1;
        chk("c_rnd_req_close", {31'd0, c_rnd_req}, 1);
        @(posedge clk); #1;
        c_in_valid = 1'b0; c_in_last = 1'b0;
        #1;
        chk("c_rnd_req_idle", {31'd0, c_rnd_req}, 0);
        chk("c_unmasked", {28'd0, c_out_data[3:0] ^ c_out_data[7:4] ^ c_out_data[11:8]}, 32'h7);

        // Refresh, single operand (1,2,4), rnd (F,9) -> (E,B,2)
        qc.push_back('{data: 12'h2BE, nops: 3'd1});
        c_in_valid = 1'b1; c_in_data = 12'h421; c_in_last = 1'b1; c_rnd = 8'h9F;
        #1;
        chk("c_rnd_req_single", {31'd0, c_rnd_req}, 1);
        @(posedge clk); #1;
        c_in_valid = 1'b0; c_in_last = 1'b0;
        chk("c_single_valid", {31'd0, c_out_valid}, 1);
        @(posedge clk); #1;

        // Asynchronous reset after 2 of 3 operands
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, a_out_valid}, 0);
        chk("mid_rst_out_data",  {24'd0, a_out_data}, 0);
        chk("mid_rst_out_nops",  {29'd0, a_out_nops}, 0);
        chk("mid_rst_in_ready",  {31'd0, a_in_ready}, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        qa.push_back('{data: 12'h005, nops: 3'd1});
        send_a(8'h05, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
